gpio_seq: RTL and testbench
===========================

GPIO_SEQ -- requirements
Module: gpio_seq

Interface
REQ-001 The block SHALL have parameter GPIO_BASE, default 32'h0, the bus base address of the target GPIO peripheral.
REQ-002 The block SHALL have parameter PERIOD_W, default 24, the width of the interval counter and PERIOD register.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port we_i, input, 1, the slave-side write enable.
REQ-006 The block SHALL have port req_i, input, 1, the slave-side request.
REQ-007 The block SHALL have port addr_i, input, 32, the slave-side address; only addr_i[4:0] SHALL be decoded.
REQ-008 The block SHALL have port data_i, input, 32, the slave-side write data.
REQ-009 The block SHALL have port data_o, output, 32, the slave-side read data (combinational).
REQ-010 The block SHALL have port ack_o, output, 1, the slave-side acknowledge, equal to req_i in the same cycle.
REQ-011 The block SHALL have ports m_req_o, m_we_o (output, 1), m_addr_o, m_data_o (output, 32) and m_ack_i (input, 1), the master-side write port to the GPIO.

Function
REQ-012 Register map: 0x00 CTRL (bit0 EN, bit1 ONESHOT); 0x04 PERIOD[PERIOD_W-1:0]; 0x08 STATUS (read-only: bit0 BUSY, bits[3:2] IDX); 0x10/0x14/0x18/0x1C PAT0..PAT3 (32 bits each).
REQ-013 Writes SHALL take effect when req_i=1 and we_i=1; reads of unmapped offsets SHALL return 0; writes to STATUS or unmapped offsets SHALL be ignored.
REQ-014 The FSM SHALL have states IDLE, WAIT and WRITE.
REQ-015 IDLE -> WAIT when EN=1; on entry the counter SHALL load 0 and IDX SHALL be 0.
REQ-016 In WAIT the counter SHALL increment each cycle; when counter equals max(PERIOD,1)-1 the FSM SHALL go to WRITE.
REQ-017 In WRITE: m_req_o=1, m_we_o=1, m_addr_o=GPIO_BASE+32'h4, m_data_o=PAT[IDX], all held stable until the cycle m_ack_i=1.
REQ-018 On m_ack_i=1 in WRITE: IDX SHALL advance modulo 4 (3 wraps to 0), the counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-019 ONESHOT=1: after the acked write of IDX=3, EN SHALL clear, IDX SHALL return to 0 and the FSM SHALL go to IDLE.
REQ-020 EN cleared by software in WAIT: go to IDLE next cycle; IDX SHALL return to 0.
REQ-021 EN cleared by software in WRITE: the pending write SHALL complete (no m_req_o drop before m_ack_i), then go to IDLE.
REQ-022 A software CTRL write and the ONESHOT auto-clear in the same cycle: the software write SHALL win.
REQ-023 PAT/PERIOD writes during operation SHALL take effect at the next WAIT comparison or WRITE entry; m_data_o SHALL NOT change during an active WRITE.
REQ-024 BUSY SHALL be 1 in WAIT and WRITE, 0 in IDLE.
REQ-025 Outside WRITE, m_req_o, m_we_o SHALL be 0 and m_addr_o, m_data_o SHALL be 0.

Reset
REQ-026 While rst=1 at a clock edge: CTRL, PERIOD, PAT0..PAT3, counter and IDX SHALL be 0 and the FSM SHALL be IDLE.
REQ-027 All master-side outputs SHALL be 0 from the first edge with rst=1; a WRITE in progress SHALL be abandoned.
REQ-028 data_o SHALL be 0 while rst=1.

Configuration
REQ-029 With macro GPIO_SEQ_IRQ_EN defined, the block SHALL have output irq_o (1 bit), pulsing high for exactly one cycle after each acked write with IDX=3, reset value 0.
REQ-030 Without GPIO_SEQ_IRQ_EN, port irq_o and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 PERIOD=3, PAT0..3=1,2,3,4, EN=1, m_ack_i tied 1 -> writes of 1,2,3,4,1 to address 0x4, one every 4 cycles (3 WAIT + 1 WRITE).
REQ-032 PERIOD=0, EN=1, m_ack_i delayed 5 cycles per write -> m_req_o held 6 cycles with stable m_data_o; next write 1 WAIT cycle after ack.
REQ-033 CTRL=0x3, PERIOD=2 -> exactly 4 writes (PAT0..PAT3), then STATUS=0, CTRL reads 0x2.
REQ-034 EN cleared while m_req_o=1, m_ack_i withheld 3 cycles -> m_req_o stays 1 until ack, then IDLE, no further writes.
REQ-035 rst=1 asserted mid-WRITE -> next cycle m_req_o=0, all registers read 0, STATUS=0.
REQ-036 With GPIO_SEQ_IRQ_EN, PERIOD=1, continuous mode -> irq_o single-cycle pulse every 8 cycles, first after 4th write ack.

Source files
------------

// File: rtl/gpio_seq.sv
// gpio_seq: register-programmed pattern sequencer.
// Every PERIOD clocks it writes the next of four 32-bit patterns
// (PAT0..PAT3) to the data register (offset 0x4) of a GPIO peripheral
// through a simple req/ack master port.
// Optional build macro GPIO_SEQ_IRQ_EN adds output irq_o. It pulses for
// one cycle after each acknowledged write of PAT3.
`timescale 1ns/1ps

module gpio_seq #(
  parameter logic [31:0] GPIO_BASE = 32'h0,
  parameter int          PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic        m_ack_i
`ifdef GPIO_SEQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_PERIOD = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [PERIOD_W-1:0] PERIOD_ONE = 1;

  state_t              state_reg;
  logic                en_reg;
  logic                oneshot_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] count_reg;
  logic [1:0]          idx_reg;
  logic [31:0]         pat_reg [4];
  logic [31:0]         m_data_reg;

  logic [4:0]          offs;
  logic                wr_en;
  logic                wr_ctrl;
  logic [PERIOD_W-1:0] count_last;
  logic                busy;
  logic                unused_addr;

  assign offs        = addr_i[4:0];
  assign wr_en       = req_i & we_i;
  assign wr_ctrl     = wr_en && (offs == OFF_CTRL);
  assign busy        = (state_reg != ST_IDLE);
  assign unused_addr = ^addr_i[31:5];

  // Last counter value of a WAIT interval; PERIOD=0 behaves like PERIOD=1.
  assign count_last = (period_reg == '0) ? '0 : (period_reg - PERIOD_ONE);

  assign ack_o = req_i;

  // PERIOD register, read by the FSM live at every WAIT comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_reg <= '0;
    end else if (wr_en && (offs == OFF_PERIOD)) begin
      period_reg <= data_i[PERIOD_W-1:0];
    end
  end

  // Pattern registers PAT0..PAT3 at 0x10..0x1C, one writer per entry.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pat
      localparam logic [4:0] PAT_OFF = 5'(16 + 4 * gi);
      // Capture software writes to this pattern slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          pat_reg[gi] <= '0;
        end else if (wr_en && (offs == PAT_OFF)) begin
          pat_reg[gi] <= data_i;
        end
      end
    end
  endgenerate

  // Sequencer FSM plus CTRL. A software CTRL write is applied last so that
  // it overrides the one-shot auto-clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      en_reg      <= 1'b0;
      oneshot_reg <= 1'b0;
      count_reg   <= '0;
      idx_reg     <= 2'd0;
      m_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          m_data_reg <= '0;
          if (en_reg) begin
            state_reg <= ST_WAIT;
            count_reg <= '0;
            idx_reg   <= 2'd0;
          end
        end
        ST_WAIT: begin
          if (!en_reg) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            idx_reg   <= 2'd0;
          end else if (count_reg >= count_last) begin
            // >= rather than == so a PERIOD shrunk mid-interval cannot
            // strand the counter past its terminal value.
            state_reg  <= ST_WRITE;
            m_data_reg <= pat_reg[idx_reg];
          end else begin
            count_reg <= count_reg + PERIOD_ONE;
          end
        end
        ST_WRITE: begin
          if (m_ack_i) begin
            count_reg  <= '0;
            m_data_reg <= '0;
            if (oneshot_reg && (idx_reg == 2'd3)) begin
              state_reg <= ST_IDLE;
              idx_reg   <= 2'd0;
              en_reg    <= 1'b0;
            end else if (!en_reg) begin
              state_reg <= ST_IDLE;
              idx_reg   <= 2'd0;
            end else begin
              state_reg <= ST_WAIT;
              idx_reg   <= idx_reg + 2'd1;
            end
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          count_reg  <= '0;
          idx_reg    <= 2'd0;
          m_data_reg <= '0;
        end
      endcase
      if (wr_ctrl) begin
        en_reg      <= data_i[0];
        oneshot_reg <= data_i[1];
      end
    end
  end

  // Master port: driven only while WRITE; data frozen at WRITE entry.
  always_comb begin
    m_req_o  = (state_reg == ST_WRITE);
    m_we_o   = (state_reg == ST_WRITE);
    m_addr_o = (state_reg == ST_WRITE) ? (GPIO_BASE + 32'h4) : 32'h0;
    m_data_o = m_data_reg;
  end

  // Register read mux; unmapped offsets and reset read as zero.
  always_comb begin
    data_o = 32'h0;
    if (!rst) begin
      case (offs)
        OFF_CTRL:   data_o = {30'h0, oneshot_reg, en_reg};
        OFF_PERIOD: data_o[PERIOD_W-1:0] = period_reg;
        OFF_STATUS: data_o = {28'h0, idx_reg, 1'b0, busy};
        5'h10:      data_o = pat_reg[0];
        5'h14:      data_o = pat_reg[1];
        5'h18:      data_o = pat_reg[2];
        5'h1C:      data_o = pat_reg[3];
        default:    data_o = 32'h0;
      endcase
    end
  end

`ifdef GPIO_SEQ_IRQ_EN
  logic irq_reg;

  // One-cycle pulse following the acknowledged write of PAT3.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (state_reg == ST_WRITE) && m_ack_i && (idx_reg == 2'd3);
    end
  end

  assign irq_o = irq_reg;
`endif

endmodule

// File: tb/tb_gpio_seq.sv
// Directed testbench for gpio_seq: register access, continuous sequencing,
// slow acknowledge, one-shot, software-stop, reset abort and optional IRQ.
`timescale 1ns/1ps

module tb_gpio_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic        m_ack_i;
`ifdef GPIO_SEQ_IRQ_EN
  logic        irq_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  gpio_seq #(.GPIO_BASE(32'h0), .PERIOD_W(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .ack_o   (ack_o),
    .m_req_o (m_req_o),
    .m_we_o  (m_we_o),
    .m_addr_o(m_addr_o),
    .m_data_o(m_data_o),
    .m_ack_i (m_ack_i)
`ifdef GPIO_SEQ_IRQ_EN
    ,
    .irq_o   (irq_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = addr;
    data_i = data;
    tick();
    req_i  = 1'b0;
    we_i   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    addr_i = addr;
    #1;
    check(tag, data_o, exp);
  endtask

  // Clock until m_req_o is seen (at least one clock), bounded.
  task automatic wait_req(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_req_o && n < bound);
  endtask

  initial begin
    int n;
    int extra;
    logic [31:0] regs [6];

    rst = 1'b1; we_i = 1'b0; req_i = 1'b0; addr_i = '0; data_i = '0; m_ack_i = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_m_req", {31'h0, m_req_o}, 32'h0);
    check("rst_m_data", m_data_o, 32'h0);
    read_check("rst_data_o", 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    read_check("ctrl_after_rst", 32'h0, 32'h0);
    read_check("status_after_rst", 32'h8, 32'h0);
    req_i = 1'b1;
    #1;
    check("ack_follows_req", {31'h0, ack_o}, 32'h1);
    req_i = 1'b0;
    #1;
    check("ack_low", {31'h0, ack_o}, 32'h0);

    // Unmapped and read-only offsets
    bus_write(32'h0C, 32'hFFFF_FFFF);
    read_check("unmapped_read", 32'h0C, 32'h0);
    bus_write(32'h08, 32'hFFFF_FFFF);
    read_check("status_ro", 32'h8, 32'h0);
    bus_write(32'h04, 32'hFF12_3456);
    read_check("period_width", 32'h4, 32'h0012_3456);

    // Continuous mode, PERIOD=3, ack tied high: 1,2,3,4,1 every 4 cycles
    m_ack_i = 1'b1;
    bus_write(32'h04, 32'd3);
    bus_write(32'h10, 32'd1);
    bus_write(32'h14, 32'd2);
    bus_write(32'h18, 32'd3);
    bus_write(32'h1C, 32'd4);
    read_check("pat2_read", 32'h18, 32'd3);
    bus_write(32'h00, 32'h1);
    for (int k = 0; k < 5; k++) begin
      wait_req(12, n);
      check("A_gap", n, 32'd4);
      check("A_req", {31'h0, m_req_o}, 32'h1);
      check("A_we", {31'h0, m_we_o}, 32'h1);
      check("A_addr", m_addr_o, 32'h4);
      check("A_data", m_data_o, 32'((k % 4) + 1));
      read_check("A_status", 32'h8, 32'(((k % 4) << 2) | 1));
    end
    bus_write(32'h00, 32'h0);
    tick();
    read_check("A_stop_status", 32'h8, 32'h0);
    check("A_stop_req", {31'h0, m_req_o}, 32'h0);
    check("A_stop_addr", m_addr_o, 32'h0);

    // PERIOD=0, slow ack: req held 6 cycles, next write 1 WAIT cycle later
    m_ack_i = 1'b0;
    bus_write(32'h04, 32'd0);
    bus_write(32'h00, 32'h1);
    wait_req(12, n);
    check("B_first_gap", n, 32'd2);
    check("B_data0", m_data_o, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("B_req_held", {31'h0, m_req_o}, 32'h1);
      check("B_data_held", m_data_o, 32'd1);
    end
    m_ack_i = 1'b1;
    tick();
    check("B_req_drop", {31'h0, m_req_o}, 32'h0);
    m_ack_i = 1'b0;
    wait_req(12, n);
    check("B_next_gap", n, 32'd1);
    check("B_data1", m_data_o, 32'd2);
    // PAT write during an active WRITE must not disturb m_data_o
    bus_write(32'h14, 32'h55);
    check("B_data_stable", m_data_o, 32'd2);
    // Software stop mid-WRITE: request held until ack, then idle
    bus_write(32'h00, 32'h0);
    check("B_stop_req_held", {31'h0, m_req_o}, 32'h1);
    tick();
    tick();
    check("B_stop_req_held2", {31'h0, m_req_o}, 32'h1);
    m_ack_i = 1'b1;
    tick();
    check("B_stop_req_drop", {31'h0, m_req_o}, 32'h0);
    read_check("B_stop_status", 32'h8, 32'h0);
    m_ack_i = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_req_o) extra++;
    end
    check("B_no_more_writes", extra, 32'd0);
    bus_write(32'h14, 32'd2);

    // One-shot, PERIOD=2: exactly PAT0..PAT3 then stop with CTRL=0x2
    m_ack_i = 1'b1;
    bus_write(32'h04, 32'd2);
    bus_write(32'h00, 32'h3);
    for (int k = 0; k < 4; k++) begin
      wait_req(12, n);
      check("C_gap", n, 32'd3);
      check("C_data", m_data_o, 32'(k + 1));
    end
    tick();
    read_check("C_status", 32'h8, 32'h0);
    read_check("C_ctrl", 32'h0, 32'h2);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_req_o) extra++;
    end
    check("C_no_more_writes", extra, 32'd0);

    // Software CTRL write coinciding with the one-shot auto-clear wins
    bus_write(32'h04, 32'd0);
    bus_write(32'h00, 32'h3);
    for (int k = 0; k < 4; k++) begin
      wait_req(12, n);
      check("D_gap", n, 32'd2);
      check("D_data", m_data_o, 32'(k + 1));
    end
    bus_write(32'h00, 32'h3);
    read_check("D_ctrl_kept", 32'h0, 32'h3);
    wait_req(12, n);
    check("D_restart_req", {31'h0, m_req_o}, 32'h1);
    check("D_restart_data", m_data_o, 32'd1);

    // Reset asserted mid-WRITE abandons it and clears everything
    m_ack_i = 1'b0;
    tick();
    check("E_in_write", {31'h0, m_req_o}, 32'h1);
    rst = 1'b1;
    tick();
    check("E_req", {31'h0, m_req_o}, 32'h0);
    check("E_we", {31'h0, m_we_o}, 32'h0);
    check("E_addr", m_addr_o, 32'h0);
    check("E_data", m_data_o, 32'h0);
    read_check("E_status_in_rst", 32'h8, 32'h0);
    rst = 1'b0;
    regs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C};
    for (int i = 0; i < 6; i++) begin
      read_check("E_reg_cleared", regs[i], 32'h0);
    end
    tick();
    check("E_stays_idle", {31'h0, m_req_o}, 32'h0);

`ifdef GPIO_SEQ_IRQ_EN
    // IRQ: PERIOD=1 continuous, pulse after 4th ack then every 8 cycles
    check("F_irq_rst", {31'h0, irq_o}, 32'h0);
    m_ack_i = 1'b1;
    bus_write(32'h04, 32'd1);
    bus_write(32'h00, 32'h1);
    n = 0;
    while (!irq_o && n < 30) begin
      tick();
      n++;
    end
    check("F_irq_first", n, 32'd9);
    tick();
    check("F_irq_width", {31'h0, irq_o}, 32'h0);
    n = 0;
    while (!irq_o && n < 30) begin
      tick();
      n++;
    end
    check("F_irq_spacing", n, 32'd7);
    bus_write(32'h00, 32'h0);
    m_ack_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
